// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver constants and state encoding
package uart_pkg;

  // Strobes per serial bit; the baud generator derives its rx divisor from this too.
  localparam int OVERSAMPLE = 8;

  // Strobe index at the centre of the start bit, counted from the detection strobe.
  localparam logic [2:0] START_MID = 3'(OVERSAMPLE / 2 - 1);

  // Last strobe index of a bit period; data and stop bits are sampled here.
  localparam logic [2:0] BIT_LAST = 3'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchronizer resetting to the idle-high level
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous pin; both stages come out of reset high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8x oversampled UART receiver with framing-error detection
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_bd_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam logic [2:0] BIT_MAX = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q,  state_d;
  logic [2:0]           tick_q,   tick_d;
  logic [2:0]           bit_q,    bit_d;
  logic [DATA_BITS-1:0] shreg_q,  shreg_d;
  logic [DATA_BITS-1:0] data_q,   data_d;
  logic                 valid_q,  valid_d;
  logic                 ferr_q,   ferr_d;
  logic                 busy_q;

  sync_2ff u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (rxd),
    .q_o   (rx_s)
  );

  // Frame sequencing: all decisions are taken on strobes and use only the synchronized line.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_bd_en && !rx_s) begin
          state_d = ST_START;
          tick_d  = 3'd0;
        end
      end
      ST_START: begin
        if (rx_bd_en) begin
          tick_d = tick_q + 3'd1;
          if (tick_q == START_MID) begin
            if (rx_s) begin
              // Line back high at mid start bit: treat it as a glitch.
              state_d = ST_IDLE;
            end else begin
              tick_d  = 3'd0;
              bit_d   = 3'd0;
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (rx_bd_en) begin
          tick_d = tick_q + 3'd1;
          if (tick_q == BIT_LAST) begin
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (bit_q == BIT_MAX) begin
              state_d = ST_STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
      end
      ST_STOP: begin
        if (rx_bd_en) begin
          tick_d = tick_q + 3'd1;
          if (tick_q == BIT_LAST) begin
            if (rx_s) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              // A low stop bit may be the start of a break; wait for the line to recover.
              ferr_d  = 1'b1;
              state_d = ST_WAIT_HIGH;
            end
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_bd_en && rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; busy lags the state register by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tick_q  <= 3'd0;
      bit_q   <= 3'd0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_q != ST_IDLE);
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx (8-bit and 7-bit instances)
module tb_uart_rx;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_bd_en = 1'b0;
  logic       rxd = 1'b1;
  logic       rxd7 = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, rx_busy;
  logic [6:0] rx_data7;
  logic       rx_valid7, frame_err7, rx_busy7;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t exp7_q[$];

  uart_rx #(.DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_bd_en  (rx_bd_en),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  uart_rx #(.DATA_BITS(7)) dut7 (
    .clk       (clk),
    .rst       (rst),
    .rx_bd_en  (rx_bd_en),
    .rxd       (rxd7),
    .rx_data   (rx_data7),
    .rx_valid  (rx_valid7),
    .frame_err (frame_err7),
    .rx_busy   (rx_busy7)
  );

  // 10 MHz clock
  always #50 clk = ~clk;

  // Strobe every 11 clocks, as a 115200-baud x8 divisor would give from 10 MHz.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt = (cnt == 10) ? 0 : cnt + 1;
      rx_bd_en = (cnt == 10);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_line(input bit to7, input logic v);
    if (to7) rxd7 = v;
    else rxd = v;
  endtask

  // Sends one frame; if rst_bit >= 0 the frame is abandoned by a reset mid data bit rst_bit.
  task automatic send(input logic [7:0] data, input int nbits, input int period,
                      input logic stop_val, input bit to7, input int rst_bit);
    logic v;
    for (int i = 0; i < nbits + 2; i++) begin
      if (i == 0) v = 1'b0;
      else if (i == nbits + 1) v = stop_val;
      else v = data[i-1];
      drive_line(to7, v);
      if (rst_bit >= 0 && i == rst_bit + 1) begin
        wait_clks(period / 2);
        rst = 1'b1;
        drive_line(to7, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_rx_data", 32'(rx_data), 32'h0);
        check("rst_mid_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_mid_frame_err", 32'(frame_err), 32'h0);
        check("rst_mid_rx_busy", 32'(rx_busy), 32'h0);
        return;
      end
      wait_clks(period);
    end
  endtask

  function automatic exp_t mk(input logic err, input logic [7:0] data);
    exp_t e;
    e.err  = err;
    e.data = data;
    return e;
  endfunction

  // Scoreboard for the 8-bit receiver: every output pulse must match the oldest expectation.
  initial begin
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid || frame_err) begin
        n_checks++;
        if (prev) begin
          n_fail++;
          $display("FAIL pulse_width: valid=%0b ferr=%0b high for more than one cycle", rx_valid, frame_err);
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: valid=%0b ferr=%0b data=%02h, no pulse expected",
                   rx_valid, frame_err, rx_data);
        end else begin
          e = exp_q.pop_front();
          if (rx_valid !== !e.err || frame_err !== e.err || rx_data !== e.data) begin
            n_fail++;
            $display("FAIL frame: valid=%0b ferr=%0b data=%02h, expected valid=%0b ferr=%0b data=%02h",
                     rx_valid, frame_err, rx_data, !e.err, e.err, e.data);
          end
        end
      end
      prev = rx_valid || frame_err;
    end
  end

  // Scoreboard for the 7-bit receiver.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_valid7 || frame_err7) begin
        n_checks++;
        if (exp7_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse7: valid=%0b ferr=%0b data=%02h, no pulse expected",
                   rx_valid7, frame_err7, rx_data7);
        end else begin
          e = exp7_q.pop_front();
          if (rx_valid7 !== !e.err || frame_err7 !== e.err || rx_data7 !== e.data[6:0]) begin
            n_fail++;
            $display("FAIL frame7: valid=%0b ferr=%0b data=%02h, expected valid=%0b ferr=%0b data=%02h",
                     rx_valid7, frame_err7, rx_data7, !e.err, e.err, e.data[6:0]);
          end
        end
      end
    end
  end

  initial begin
    wait_clks(5);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_rx_busy", 32'(rx_busy), 32'h0);
    check("reset_rx_data7", 32'(rx_data7), 32'h0);
    rst = 1'b0;
    wait_clks(200);

    // Single byte
    exp_q.push_back(mk(1'b0, 8'hA5));
    send(8'hA5, 8, 88, 1'b1, 1'b0, -1);
    wait_clks(5);
    check("single_busy_low", 32'(rx_busy), 32'h0);
    wait_clks(200);
    check("single_drained", 32'(exp_q.size()), 32'h0);

    // Back-to-back frames, no idle gap
    exp_q.push_back(mk(1'b0, 8'h00));
    exp_q.push_back(mk(1'b0, 8'hFF));
    exp_q.push_back(mk(1'b0, 8'h55));
    send(8'h00, 8, 88, 1'b1, 1'b0, -1);
    send(8'hFF, 8, 88, 1'b1, 1'b0, -1);
    send(8'h55, 8, 88, 1'b1, 1'b0, -1);
    wait_clks(300);
    check("b2b_drained", 32'(exp_q.size()), 32'h0);
    check("b2b_last_data", 32'(rx_data), 32'h55);

    // Glitch start: 20 clocks low must be rejected at mid start bit
    rxd = 1'b0;
    wait_clks(20);
    rxd = 1'b1;
    wait_clks(80);
    check("glitch_busy_low", 32'(rx_busy), 32'h0);
    wait_clks(100);

    // Framing error followed by a break, then recovery
    exp_q.push_back(mk(1'b1, 8'h55));
    send(8'h3C, 8, 88, 1'b0, 1'b0, -1);
    wait_clks(2000);
    rxd = 1'b1;
    wait_clks(300);
    check("break_drained", 32'(exp_q.size()), 32'h0);
    check("break_data_held", 32'(rx_data), 32'h55);
    exp_q.push_back(mk(1'b0, 8'h81));
    send(8'h81, 8, 88, 1'b1, 1'b0, -1);
    wait_clks(300);
    check("recover_drained", 32'(exp_q.size()), 32'h0);

    // Reset during data bit 4 of 0xC3, then a clean 0x7E
    send(8'hC3, 8, 88, 1'b1, 1'b0, 4);
    wait_clks(500);
    check("rst_no_pulse_busy", 32'(rx_busy), 32'h0);
    exp_q.push_back(mk(1'b0, 8'h7E));
    send(8'h7E, 8, 88, 1'b1, 1'b0, -1);
    wait_clks(300);
    check("after_rst_drained", 32'(exp_q.size()), 32'h0);

    // Baud skew
    exp_q.push_back(mk(1'b0, 8'h96));
    send(8'h96, 8, 85, 1'b1, 1'b0, -1);
    wait_clks(100);
    exp_q.push_back(mk(1'b0, 8'h96));
    send(8'h96, 8, 91, 1'b1, 1'b0, -1);
    wait_clks(300);
    check("skew_drained", 32'(exp_q.size()), 32'h0);

    // 7-bit frame on the narrow instance
    exp7_q.push_back(mk(1'b0, 8'h4D));
    send(8'h4D, 7, 88, 1'b1, 1'b1, -1);
    wait_clks(300);
    check("w7_drained", 32'(exp7_q.size()), 32'h0);
    check("w7_rx_data", 32'(rx_data7), 32'h4D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
